// File: rtl/ibex_mem_arbiter_if.sv
// rtl/ibex_mem_arbiter_if.sv - signal bundle between the ibex requesters, the arbiter and magic memory
// Purpose: groups the instruction fetch port, the load/store port and the shared memory port.
// Ports:
//   instr_* : read-only fetch requester (req/addr in; gnt/rvalid/err/rdata out of the arbiter)
//   data_*  : load/store requester (req/we/be/addr/wdata in; gnt/rvalid/err/rdata out of the arbiter)
//   mem_*   : single-outstanding memory (read/write/addr/wdata/mbe out; rdata/resp in to the arbiter)
// Modports: slave = the arbiter's view, master = the environment (requesters plus memory).
interface ibex_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              instr_req_i;
   logic              instr_gnt_o;
   logic              instr_rvalid_o;
   logic              instr_err_o;
   logic [ADDR_W-1:0] instr_addr_i;
   logic [DATA_W-1:0] instr_rdata_o;

   logic              data_req_i;
   logic              data_we_i;
   logic [BE_W-1:0]   data_be_i;
   logic [ADDR_W-1:0] data_addr_i;
   logic [DATA_W-1:0] data_wdata_i;
   logic              data_gnt_o;
   logic              data_rvalid_o;
   logic              data_err_o;
   logic [DATA_W-1:0] data_rdata_o;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_mbe;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_resp;

   modport slave (
      input  instr_req_i, instr_addr_i,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  mem_rdata, mem_resp,
      output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
      output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
      output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe
   );

   modport master (
      output instr_req_i, instr_addr_i,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output mem_rdata, mem_resp,
      input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
      input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
      input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe
   );
endinterface

// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - round-robin arbiter of ibex instr/data ports onto one magic-memory port
// Purpose: grants one requester at a time, holds the latched request on the memory port until
//   mem_resp or a wait timeout, then returns a one-cycle rvalid (err=1 on timeout) to the owner.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ibex_mem_arbiter_if.slave (instr_*, data_*, mem_* signal groups)
// Parameters: ADDR_W, DATA_W (byte enables are DATA_W/8), TIMEOUT (0 disables the timeout).
module ibex_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input logic               clk,
   input logic               rst,
   ibex_mem_arbiter_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e            state_q, state_d;
   logic              last_d_q;    // 1 = data port was served last
   logic              owner_d_q;   // 1 = in-flight transaction belongs to the data port
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BE_W-1:0]   be_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  wait_q;

   logic              gnt_instr, gnt_data, grant, finish, timeout;

   logic              instr_rvalid_q, data_rvalid_q, instr_err_q, data_err_q;
   logic [DATA_W-1:0] instr_rdata_q, data_rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      gnt_instr = 1'b0;
      gnt_data  = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         IDLE: begin
            // Grants are combinational, so they are also masked while reset is held.
            if (!rst) begin
               gnt_data  = bus.data_req_i && (!bus.instr_req_i || !last_d_q);
               gnt_instr = bus.instr_req_i && !gnt_data;
            end
            if (gnt_data || gnt_instr) state_d = BUSY;
         end
         BUSY: begin
            // A response arriving on the last allowed cycle beats the timeout.
            timeout = (TIMEOUT > 0) && !bus.mem_resp && (wait_q == CNT_LAST);
            if (bus.mem_resp || timeout) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant  = gnt_data || gnt_instr;
   assign finish = (state_q == BUSY) && (bus.mem_resp || timeout);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_d_q       <= 1'b0;
         owner_d_q      <= 1'b0;
         we_q           <= 1'b0;
         addr_q         <= '0;
         be_q           <= '0;
         wdata_q        <= '0;
         wait_q         <= '0;
         instr_rvalid_q <= 1'b0;
         data_rvalid_q  <= 1'b0;
         instr_err_q    <= 1'b0;
         data_err_q     <= 1'b0;
         instr_rdata_q  <= '0;
         data_rdata_q   <= '0;
      end else begin
         instr_rvalid_q <= 1'b0;
         data_rvalid_q  <= 1'b0;
         instr_err_q    <= 1'b0;
         data_err_q     <= 1'b0;
         if (grant) begin
            owner_d_q <= gnt_data;
            last_d_q  <= gnt_data;
            addr_q    <= gnt_data ? bus.data_addr_i : bus.instr_addr_i;
            we_q      <= gnt_data && bus.data_we_i;
            be_q      <= gnt_data ? bus.data_be_i : '1;
            wdata_q   <= gnt_data ? bus.data_wdata_i : '0;
            wait_q    <= '0;
         end else if (finish) begin
            // Timeout returns zero data; a real response is passed through unchanged.
            if (owner_d_q) begin
               data_rvalid_q <= 1'b1;
               data_err_q    <= timeout;
               data_rdata_q  <= timeout ? '0 : bus.mem_rdata;
            end else begin
               instr_rvalid_q <= 1'b1;
               instr_err_q    <= timeout;
               instr_rdata_q  <= timeout ? '0 : bus.mem_rdata;
            end
         end else if (state_q == BUSY) begin
            wait_q <= wait_q + 1'b1;
         end
      end
   end

   assign bus.instr_gnt_o    = gnt_instr;
   assign bus.data_gnt_o     = gnt_data;
   assign bus.instr_rvalid_o = instr_rvalid_q;
   assign bus.instr_err_o    = instr_err_q;
   assign bus.instr_rdata_o  = instr_rdata_q;
   assign bus.data_rvalid_o  = data_rvalid_q;
   assign bus.data_err_o     = data_err_q;
   assign bus.data_rdata_o   = data_rdata_q;

   assign bus.mem_read  = (state_q == BUSY) && !we_q;
   assign bus.mem_write = (state_q == BUSY) && we_q;
   assign bus.mem_addr  = (state_q == BUSY) ? addr_q  : '0;
   assign bus.mem_wdata = (state_q == BUSY) ? wdata_q : '0;
   assign bus.mem_mbe   = (state_q == BUSY) ? be_q    : '0;
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb/tb_ibex_mem_arbiter.sv - self-checking bench for ibex_mem_arbiter
module tb_ibex_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ibex_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   ibex_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic idle_inputs();
      bus.instr_req_i  = 1'b0;
      bus.instr_addr_i = '0;
      bus.data_req_i   = 1'b0;
      bus.data_we_i    = 1'b0;
      bus.data_be_i    = '0;
      bus.data_addr_i  = '0;
      bus.data_wdata_i = '0;
      bus.mem_rdata    = '0;
      bus.mem_resp     = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.instr_req_i = 1'b1;
      bus.data_req_i  = 1'b1;
      bus.mem_resp    = 1'b1;
      sample();
      n_checks++; if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b00) $display("FAIL rst_gnt got=%b exp=00", {bus.instr_gnt_o, bus.data_gnt_o}); else n_pass++;
      n_checks++; if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o} !== 4'b0) $display("FAIL rst_rvalid_err got=%b exp=0000", {bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o}); else n_pass++;
      n_checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00) $display("FAIL rst_mem_rw got=%b exp=00", {bus.mem_read, bus.mem_write}); else n_pass++;
      n_checks++; if ({bus.instr_rdata_o, bus.data_rdata_o} !== 64'h0) $display("FAIL rst_rdata got=%h exp=0", {bus.instr_rdata_o, bus.data_rdata_o}); else n_pass++;
      n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_mbe} !== 68'h0) $display("FAIL rst_mem_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.mem_mbe}); else n_pass++;
      next_cycle();
      idle_inputs();
      rst = 1'b0;
   endtask

   task automatic test_instr_read();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h80;
      sample();
      n_checks++; if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b10) $display("FAIL rd_gnt got=%b exp=10", {bus.instr_gnt_o, bus.data_gnt_o}); else n_pass++;
      next_cycle();
      bus.instr_req_i  = 1'b0;
      bus.instr_addr_i = 32'hFFFF_FFF0;
      for (int c = 1; c <= 2; c++) begin
         sample();
         n_checks++; if ({bus.mem_read, bus.mem_write} !== 2'b10) $display("FAIL rd_mem_rw c%0d got=%b exp=10", c, {bus.mem_read, bus.mem_write}); else n_pass++;
         n_checks++; if (bus.mem_addr !== 32'h80 || bus.mem_mbe !== 4'hF) $display("FAIL rd_mem_addr_mbe c%0d got=%h/%h exp=80/f", c, bus.mem_addr, bus.mem_mbe); else n_pass++;
         next_cycle();
      end
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'h0000_0013;
      sample();
      n_checks++; if (bus.instr_rvalid_o !== 1'b0) $display("FAIL rd_early_rvalid got=%b exp=0", bus.instr_rvalid_o); else n_pass++;
      next_cycle();
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = 32'h1111_2222;
      sample();
      n_checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o} !== 3'b100) $display("FAIL rd_rvalid got=%b exp=100", {bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o}); else n_pass++;
      n_checks++; if (bus.instr_rdata_o !== 32'h13) $display("FAIL rd_rdata got=%h exp=00000013", bus.instr_rdata_o); else n_pass++;
      n_checks++; if (bus.mem_read !== 1'b0) $display("FAIL rd_mem_read_drop got=%b exp=0", bus.mem_read); else n_pass++;
      next_cycle();
      sample();
      n_checks++; if (bus.instr_rvalid_o !== 1'b0 || bus.instr_rdata_o !== 32'h13) $display("FAIL rd_hold got=%b/%h exp=0/00000013", bus.instr_rvalid_o, bus.instr_rdata_o); else n_pass++;
      next_cycle();
   endtask

   task automatic test_alternation();
      rst = 1'b1;
      idle_inputs();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h1000;
      bus.data_req_i   = 1'b1;
      bus.data_addr_i  = 32'h2000;
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bus.mem_resp = (k % 2 == 1);
         sample();
         n_checks++; if (bus.data_gnt_o !== (k % 4 == 0) || bus.instr_gnt_o !== (k % 4 == 2)) $display("FAIL alt_gnt k%0d got d=%b i=%b exp d=%b i=%b", k, bus.data_gnt_o, bus.instr_gnt_o, (k % 4 == 0), (k % 4 == 2)); else n_pass++;
         next_cycle();
      end
      idle_inputs();
   endtask

   task automatic test_data_write();
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = 1'b1;
      bus.data_be_i    = 4'h3;
      bus.data_addr_i  = 32'h100;
      bus.data_wdata_i = 32'hDEAD_BEEF;
      sample();
      n_checks++; if ({bus.data_gnt_o, bus.instr_gnt_o} !== 2'b10) $display("FAIL wr_gnt got=%b exp=10", {bus.data_gnt_o, bus.instr_gnt_o}); else n_pass++;
      next_cycle();
      bus.data_req_i   = 1'b0;
      bus.data_addr_i  = 32'h5555;
      bus.data_wdata_i = '0;
      bus.data_be_i    = 4'hF;
      sample();
      n_checks++; if ({bus.mem_write, bus.mem_read} !== 2'b10) $display("FAIL wr_mem_rw got=%b exp=10", {bus.mem_write, bus.mem_read}); else n_pass++;
      n_checks++; if (bus.mem_addr !== 32'h100 || bus.mem_mbe !== 4'h3 || bus.mem_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_mem_bus got=%h/%h/%h exp=100/3/deadbeef", bus.mem_addr, bus.mem_mbe, bus.mem_wdata); else n_pass++;
      next_cycle();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      sample();
      n_checks++; if (bus.data_rvalid_o !== 1'b0) $display("FAIL wr_early_rvalid got=%b exp=0", bus.data_rvalid_o); else n_pass++;
      next_cycle();
      bus.mem_resp = 1'b0;
      sample();
      n_checks++; if ({bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o} !== 3'b100) $display("FAIL wr_rvalid got=%b exp=100", {bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o}); else n_pass++;
      n_checks++; if (bus.data_rdata_o !== 32'h1234_5678) $display("FAIL wr_rdata got=%h exp=12345678", bus.data_rdata_o); else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_timeout();
      bus.data_req_i  = 1'b1;
      bus.data_addr_i = 32'h200;
      sample();
      n_checks++; if (bus.data_gnt_o !== 1'b1) $display("FAIL to_gnt got=%b exp=1", bus.data_gnt_o); else n_pass++;
      next_cycle();
      bus.data_req_i = 1'b0;
      for (int c = 1; c <= TO; c++) begin
         sample();
         n_checks++; if (bus.mem_read !== 1'b1) $display("FAIL to_wait c%0d got=%b exp=1", c, bus.mem_read); else n_pass++;
         next_cycle();
      end
      bus.data_req_i = 1'b1;
      sample();
      n_checks++; if (bus.mem_read !== 1'b0) $display("FAIL to_drop got=%b exp=0", bus.mem_read); else n_pass++;
      n_checks++; if ({bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o, bus.instr_err_o} !== 4'b1100) $display("FAIL to_err got=%b exp=1100", {bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o, bus.instr_err_o}); else n_pass++;
      n_checks++; if (bus.data_rdata_o !== 32'h0) $display("FAIL to_rdata got=%h exp=0", bus.data_rdata_o); else n_pass++;
      n_checks++; if (bus.data_gnt_o !== 1'b1) $display("FAIL to_regrant got=%b exp=1", bus.data_gnt_o); else n_pass++;
      next_cycle();
      bus.data_req_i = 1'b0;
      bus.mem_resp   = 1'b1;
      bus.mem_rdata  = 32'hA5A5_A5A5;
      next_cycle();
      bus.mem_resp = 1'b0;
      sample();
      n_checks++; if ({bus.data_rvalid_o, bus.data_err_o} !== 2'b10 || bus.data_rdata_o !== 32'hA5A5_A5A5) $display("FAIL to_after got=%b/%h exp=10/a5a5a5a5", {bus.data_rvalid_o, bus.data_err_o}, bus.data_rdata_o); else n_pass++;
      next_cycle();
      // Response on the very last allowed cycle must win over the timeout.
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h240;
      next_cycle();
      bus.instr_req_i = 1'b0;
      for (int c = 1; c < TO; c++) next_cycle();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'h0000_0077;
      sample();
      n_checks++; if (bus.mem_read !== 1'b1) $display("FAIL to_race_busy got=%b exp=1", bus.mem_read); else n_pass++;
      next_cycle();
      bus.mem_resp = 1'b0;
      sample();
      n_checks++; if ({bus.instr_rvalid_o, bus.instr_err_o} !== 2'b10 || bus.instr_rdata_o !== 32'h77) $display("FAIL to_race got=%b/%h exp=10/00000077", {bus.instr_rvalid_o, bus.instr_err_o}, bus.instr_rdata_o); else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_reset_mid_busy();
      bus.data_req_i  = 1'b1;
      bus.data_addr_i = 32'h300;
      sample();
      n_checks++; if (bus.data_gnt_o !== 1'b1) $display("FAIL rmb_gnt got=%b exp=1", bus.data_gnt_o); else n_pass++;
      next_cycle();
      bus.data_req_i = 1'b0;
      sample();
      n_checks++; if (bus.mem_read !== 1'b1) $display("FAIL rmb_busy got=%b exp=1", bus.mem_read); else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.mem_read !== 1'b0) $display("FAIL rmb_async got=%b exp=0", bus.mem_read); else n_pass++;
      next_cycle();
      rst = 1'b0;
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'h0BAD_0BAD;
      sample();
      n_checks++; if (bus.mem_read !== 1'b0) $display("FAIL rmb_idle got=%b exp=0", bus.mem_read); else n_pass++;
      next_cycle();
      bus.mem_resp = 1'b0;
      sample();
      n_checks++; if ({bus.data_rvalid_o, bus.instr_rvalid_o} !== 2'b00) $display("FAIL rmb_no_rvalid got=%b exp=00", {bus.data_rvalid_o, bus.instr_rvalid_o}); else n_pass++;
      next_cycle();
      bus.data_req_i  = 1'b1;
      bus.instr_req_i = 1'b1;
      sample();
      n_checks++; if ({bus.data_gnt_o, bus.instr_gnt_o} !== 2'b10) $display("FAIL rmb_first_gnt got=%b exp=10", {bus.data_gnt_o, bus.instr_gnt_o}); else n_pass++;
      next_cycle();
      idle_inputs();
      bus.mem_resp = 1'b1;
      next_cycle();
      bus.mem_resp = 1'b0;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      bus.data_req_i  = 1'b1;
      bus.data_addr_i = 32'h400;
      sample();
      n_checks++; if (bus.data_gnt_o !== 1'b1) $display("FAIL b2b_gnt_d got=%b exp=1", bus.data_gnt_o); else n_pass++;
      next_cycle();
      bus.data_req_i   = 1'b0;
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h500;
      bus.mem_resp     = 1'b1;
      bus.mem_rdata    = 32'h0000_CAFE;
      sample();
      n_checks++; if (bus.instr_gnt_o !== 1'b0) $display("FAIL b2b_busy_gnt got=%b exp=0", bus.instr_gnt_o); else n_pass++;
      next_cycle();
      bus.mem_rdata = 32'h0000_0BAD;
      sample();
      n_checks++; if ({bus.data_rvalid_o, bus.instr_gnt_o} !== 2'b11 || bus.data_rdata_o !== 32'hCAFE) $display("FAIL b2b_same_cycle got=%b/%h exp=11/0000cafe", {bus.data_rvalid_o, bus.instr_gnt_o}, bus.data_rdata_o); else n_pass++;
      next_cycle();
      bus.instr_req_i = 1'b0;
      bus.mem_resp    = 1'b0;
      sample();
      n_checks++; if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.mem_read} !== 3'b001 || bus.mem_addr !== 32'h500) $display("FAIL b2b_stray got=%b/%h exp=001/500", {bus.instr_rvalid_o, bus.data_rvalid_o, bus.mem_read}, bus.mem_addr); else n_pass++;
      next_cycle();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 32'h0000_600D;
      next_cycle();
      bus.mem_resp = 1'b0;
      sample();
      n_checks++; if (bus.instr_rvalid_o !== 1'b1 || bus.instr_rdata_o !== 32'h600D || bus.data_rdata_o !== 32'hCAFE) $display("FAIL b2b_second got=%b/%h/%h exp=1/0000600d/0000cafe", bus.instr_rvalid_o, bus.instr_rdata_o, bus.data_rdata_o); else n_pass++;
      next_cycle();
      idle_inputs();
   endtask

   // Transaction-level reference: a granted request occupies memory until it is answered or
   // until the absolute cycle grant+TO, and its result is reported on the following cycle.
   task automatic test_random();
      bit          m_busy = 0, m_own_d = 0, m_we = 0, m_last_d = 0;
      logic [31:0] m_addr = '0, m_wdata = '0;
      logic [3:0]  m_be = '0;
      int          m_deadline = 0;
      bit          m_irv = 0, m_drv = 0, m_ierr = 0, m_derr = 0;
      logic [31:0] m_irdata = '0, m_drdata = '0;
      bit          gd, gi;
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.instr_req_i  = ($urandom_range(0, 9) < 6);
         bus.instr_addr_i = $urandom;
         bus.data_req_i   = ($urandom_range(0, 9) < 6);
         bus.data_we_i    = $urandom_range(0, 1);
         bus.data_be_i    = 4'($urandom);
         bus.data_addr_i  = $urandom;
         bus.data_wdata_i = $urandom;
         bus.mem_resp     = ($urandom_range(0, 3) == 0);
         bus.mem_rdata    = $urandom;
         sample();
         gd = !m_busy && bus.data_req_i && (!bus.instr_req_i || !m_last_d);
         gi = !m_busy && bus.instr_req_i && !gd;
         n_checks++; if (bus.data_gnt_o !== gd || bus.instr_gnt_o !== gi) $display("FAIL rnd_gnt cyc%0d got d=%b i=%b exp d=%b i=%b", cyc, bus.data_gnt_o, bus.instr_gnt_o, gd, gi); else n_pass++;
         n_checks++; if (bus.mem_read !== (m_busy && !m_we) || bus.mem_write !== (m_busy && m_we)) $display("FAIL rnd_mem_rw cyc%0d got r=%b w=%b exp r=%b w=%b", cyc, bus.mem_read, bus.mem_write, m_busy && !m_we, m_busy && m_we); else n_pass++;
         if (m_busy) begin
            n_checks++; if (bus.mem_addr !== m_addr || bus.mem_mbe !== m_be) $display("FAIL rnd_mem_addr cyc%0d got=%h/%h exp=%h/%h", cyc, bus.mem_addr, bus.mem_mbe, m_addr, m_be); else n_pass++;
            if (m_we) begin
               n_checks++; if (bus.mem_wdata !== m_wdata) $display("FAIL rnd_mem_wdata cyc%0d got=%h exp=%h", cyc, bus.mem_wdata, m_wdata); else n_pass++;
            end
         end
         n_checks++; if ({bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.data_err_o} !== {m_irv, m_ierr, m_drv, m_derr}) $display("FAIL rnd_rvalid cyc%0d got=%b exp=%b", cyc, {bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.data_err_o}, {m_irv, m_ierr, m_drv, m_derr}); else n_pass++;
         n_checks++; if (bus.instr_rdata_o !== m_irdata || bus.data_rdata_o !== m_drdata) $display("FAIL rnd_rdata cyc%0d got=%h/%h exp=%h/%h", cyc, bus.instr_rdata_o, bus.data_rdata_o, m_irdata, m_drdata); else n_pass++;
         {m_irv, m_ierr, m_drv, m_derr} = 4'b0;
         if (m_busy && (bus.mem_resp || cyc == m_deadline)) begin
            m_busy = 0;
            if (m_own_d) begin
               m_drv = 1; m_derr = !bus.mem_resp; m_drdata = bus.mem_resp ? bus.mem_rdata : 32'h0;
            end else begin
               m_irv = 1; m_ierr = !bus.mem_resp; m_irdata = bus.mem_resp ? bus.mem_rdata : 32'h0;
            end
         end
         if (gd || gi) begin
            m_busy     = 1;
            m_own_d    = gd;
            m_last_d   = gd;
            m_we       = gd && bus.data_we_i;
            m_addr     = gd ? bus.data_addr_i : bus.instr_addr_i;
            m_be       = gd ? bus.data_be_i : 4'hF;
            m_wdata    = bus.data_wdata_i;
            m_deadline = cyc + TO;
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_instr_read();
      test_alternation();
      test_data_write();
      test_timeout();
      test_reset_mid_busy();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
